// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types
// fetch/data bus states and defaults
package pipe_ctrl_pkg;

  localparam int DIV_CYCLES_DEF = 32;
  localparam int RW_DEF = 5;

  typedef enum logic [1:0] {
    F_REQ,
    F_WAIT,
    F_HOLD,
    F_DISCARD
  } fstate_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_REQ,
    D_WAIT
  } dstate_t;

endpackage

// File: rtl/pipe_ctrl_fetch_fsm.sv
// instruction fetch handshake
// plus the held-instruction buffer
module pipe_ctrl_fetch_fsm
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_d,
  input  logic        flush,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        inst_req,
  output logic        fetch_stall,
  output logic [31:0] instr_f
);

  fstate_t     state;
  fstate_t     state_nx;
  logic [31:0] ibuf;
  logic        got;

  assign got = (state == F_WAIT) & inst_data_ok;

  // fetch state register
  always_ff @(posedge clk) begin
    if (rst) state <= F_REQ;
    else     state <= state_nx;
  end

  // capture every response taken in F_WAIT
  always_ff @(posedge clk) begin
    if (rst)      ibuf <= '0;
    else if (got) ibuf <= inst_rdata;
  end

  // next state; a flush turns an in-flight
  // fetch into a response to be dropped
  always_comb begin
    state_nx = state;
    unique case (state)
      F_REQ: begin
        if (inst_addr_ok)
          state_nx = flush ? F_DISCARD : F_WAIT;
      end
      F_WAIT: begin
        if (inst_data_ok)
          state_nx = (stall_d & !flush) ? F_HOLD : F_REQ;
        else if (flush)
          state_nx = F_DISCARD;
      end
      F_HOLD: begin
        if (!stall_d | flush) state_nx = F_REQ;
      end
      F_DISCARD: begin
        if (inst_data_ok) state_nx = F_REQ;
      end
      default: state_nx = F_REQ;
    endcase
  end

  // bus request, stall and instruction mux
  always_comb begin
    inst_req    = !rst & (state == F_REQ);
    fetch_stall = !got & (state != F_HOLD);
    instr_f     = (state == F_WAIT) ? inst_rdata : ibuf;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencing control
// hazards, divide hold, bus handshakes
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] rs_d,
  input  logic [RW-1:0] rt_d,
  input  logic          uses_rs_d,
  input  logic          uses_rt_d,
  input  logic          branch_d,
  input  logic          regwrite_e,
  input  logic          memtoreg_e,
  input  logic [RW-1:0] writereg_e,
  input  logic          regwrite_m,
  input  logic          memtoreg_m,
  input  logic [RW-1:0] writereg_m,
  input  logic          div_e,
  input  logic          mem_m,
  input  logic          exc_m,
  input  logic          inst_addr_ok,
  input  logic          inst_data_ok,
  input  logic [31:0]   inst_rdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  output logic          inst_req,
  output logic          data_req,
  output logic [31:0]   instr_f,
  output logic          div_start,
  output logic          en_f,
  output logic          en_d,
  output logic          en_e,
  output logic          en_m,
  output logic          clr_d,
  output logic          clr_e,
  output logic          clr_m,
  output logic          clr_w,
  output logic          exc_flush
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_TOP = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  function automatic logic hit(
    input logic [RW-1:0] a,
    input logic [RW-1:0] b
  );
    return (a != '0) && (a == b);
  endfunction

  logic unused_ok;
  assign unused_ok = regwrite_m;

  dstate_t       dstate;
  dstate_t       dstate_nx;
  logic          dreq;
  logic [CW-1:0] cnt;
  logic          flush;
  logic          stall_m;
  logic          stall_e;
  logic          stall_d;
  logic          div_busy;
  logic          div_go;
  logic          src_e;
  logic          src_m;
  logic          lu;
  logic          bh;
  logic          fetch_stall;
  logic          ireq;

  pipe_ctrl_fetch_fsm u_fetch (
    .clk          (clk),
    .rst          (rst),
    .stall_d      (stall_d),
    .flush        (flush),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst_req     (ireq),
    .fetch_stall  (fetch_stall),
    .instr_f      (instr_f)
  );

  // data bus state register
  always_ff @(posedge clk) begin
    if (rst) dstate <= D_IDLE;
    else     dstate <= dstate_nx;
  end

  // data handshake; no request for a
  // faulting access
  always_comb begin
    dstate_nx = dstate;
    dreq      = 1'b0;
    unique case (dstate)
      D_IDLE: begin
        dreq = mem_m & !exc_m;
        if (dreq)
          dstate_nx = data_addr_ok ? D_WAIT : D_REQ;
      end
      D_REQ: begin
        dreq = 1'b1;
        if (data_addr_ok) dstate_nx = D_WAIT;
      end
      D_WAIT: begin
        if (data_data_ok) dstate_nx = D_IDLE;
      end
      default: dstate_nx = D_IDLE;
    endcase
  end

  // hazard and stall terms
  always_comb begin
    src_e = (uses_rs_d & hit(rs_d, writereg_e))
          | (uses_rt_d & hit(rt_d, writereg_e));
    src_m = (uses_rs_d & hit(rs_d, writereg_m))
          | (uses_rt_d & hit(rt_d, writereg_m));
    lu = memtoreg_e & src_e;
    bh = branch_d
       & ((regwrite_e & src_e) | (memtoreg_m & src_m));
    flush = exc_m & (dstate == D_IDLE);
    stall_m = mem_m
            & !((dstate == D_WAIT) & data_data_ok);
    div_busy = div_e & (cnt != CNT_ONE);
    div_go = div_e & (cnt == '0) & !stall_m & !flush;
    stall_e = stall_m | div_busy;
    stall_d = stall_e | lu | bh;
  end

  // divide occupancy counter; parks at 1
  // until E can advance
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (flush)
      cnt <= '0;
    else if (div_go)
      cnt <= CNT_TOP;
    else if (cnt > CNT_ONE)
      cnt <= cnt - CNT_ONE;
    else if ((cnt == CNT_ONE) & !stall_m)
      cnt <= '0;
  end

  // register controls; reset forces all
  // stages clear and idle
  always_comb begin
    inst_req  = ireq;
    data_req  = dreq;
    div_start = div_go;
    exc_flush = flush;
    en_f  = !(stall_d | fetch_stall) | flush;
    en_d  = !stall_d;
    en_e  = !stall_e;
    en_m  = !stall_m;
    clr_d = flush | (fetch_stall & !stall_d);
    clr_e = flush | ((lu | bh) & !stall_e);
    clr_m = flush | (div_busy & !stall_m);
    clr_w = flush | stall_m;
    if (rst) begin
      data_req  = 1'b0;
      div_start = 1'b0;
      exc_flush = 1'b0;
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      en_m  = 1'b0;
      clr_d = 1'b1;
      clr_e = 1'b1;
      clr_m = 1'b1;
      clr_w = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// pipe_ctrl bench: directed vectors with
// a transaction-level reference model
module tb_pipe_ctrl;

  localparam int DC = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rs_d, rt_d, writereg_e, writereg_m;
  logic          uses_rs_d, uses_rt_d, branch_d;
  logic          regwrite_e, memtoreg_e;
  logic          regwrite_m, memtoreg_m;
  logic          div_e, mem_m, exc_m;
  logic          inst_addr_ok, inst_data_ok;
  logic [31:0]   inst_rdata;
  logic          data_addr_ok, data_data_ok;
  logic          inst_req, data_req, div_start, exc_flush;
  logic [31:0]   instr_f;
  logic          en_f, en_d, en_e, en_m;
  logic          clr_d, clr_e, clr_m, clr_w;

  int vecs = 0;
  int miss = 0;

  pipe_ctrl #(.DIV_CYCLES(DC), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d),
    .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
    .branch_d(branch_d),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .writereg_e(writereg_e),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .writereg_m(writereg_m),
    .div_e(div_e), .mem_m(mem_m), .exc_m(exc_m),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .inst_req(inst_req), .data_req(data_req),
    .instr_f(instr_f), .div_start(div_start),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
    .clr_d(clr_d), .clr_e(clr_e),
    .clr_m(clr_m), .clr_w(clr_w),
    .exc_flush(exc_flush)
  );

  always #5 clk = ~clk;

  // model: outstanding transactions and
  // elapsed divide cycles
  bit          m_fwait = 0;
  bit          m_fheld = 0;
  int          m_fdrop = 0;
  logic [31:0] m_fbuf = '0;
  bit          m_dpend = 0;
  bit          m_dbusy = 0;
  bit          m_dv = 0;
  int          m_age = 0;
  bit          armed = 0;

  logic hit_e, hit_m;
  logic x_flush, x_stall_m, x_busy, x_start;
  logic x_lu, x_bh, x_stall_e, x_stall_d;
  logic x_fstall, x_dreq, x_ireq;
  logic [31:0] x_instr;
  logic [11:0] exp_ctl, act_ctl;

  function automatic logic same(
    input logic [RW-1:0] a,
    input logic [RW-1:0] b
  );
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    hit_e = (uses_rs_d && same(rs_d, writereg_e))
         || (uses_rt_d && same(rt_d, writereg_e));
    hit_m = (uses_rs_d && same(rs_d, writereg_m))
         || (uses_rt_d && same(rt_d, writereg_m));
    x_flush = exc_m && !m_dpend && !m_dbusy;
    x_dreq = m_dpend
          || (!m_dbusy && mem_m && !exc_m);
    x_stall_m = mem_m && !(m_dbusy && data_data_ok);
    x_busy = div_e && !(m_dv && m_age == DC - 1);
    x_start = div_e && !m_dv && !x_stall_m
           && !x_flush;
    x_lu = memtoreg_e && hit_e;
    x_bh = branch_d && ((regwrite_e && hit_e)
        || (memtoreg_m && hit_m));
    x_stall_e = x_stall_m || x_busy;
    x_stall_d = x_stall_e || x_lu || x_bh;
    x_ireq = !m_fwait && !m_fheld && m_fdrop == 0;
    x_fstall = !(m_fwait && inst_data_ok)
            && !m_fheld;
    x_instr = m_fwait ? inst_rdata : m_fbuf;
    act_ctl = {inst_req, data_req, div_start,
               exc_flush, en_f, en_d, en_e, en_m,
               clr_d, clr_e, clr_m, clr_w};
    if (rst)
      exp_ctl = 12'b0000_0000_1111;
    else
      exp_ctl = {
        x_ireq, x_dreq, x_start, x_flush,
        !(x_stall_d || x_fstall) || x_flush,
        !x_stall_d, !x_stall_e, !x_stall_m,
        x_flush || (x_fstall && !x_stall_d),
        x_flush || ((x_lu || x_bh) && !x_stall_e),
        x_flush || (x_busy && !x_stall_m),
        x_flush || x_stall_m};
  end

  // model state advance
  always @(posedge clk) begin
    armed <= 1'b1;
    if (rst) begin
      m_fwait <= 0; m_fheld <= 0; m_fdrop <= 0;
      m_fbuf <= '0; m_dpend <= 0; m_dbusy <= 0;
      m_dv <= 0; m_age <= 0;
    end else begin
      if (x_ireq) begin
        if (inst_addr_ok) begin
          if (x_flush) m_fdrop <= m_fdrop + 1;
          else         m_fwait <= 1;
        end
      end else if (m_fwait) begin
        if (inst_data_ok) begin
          m_fbuf  <= inst_rdata;
          m_fwait <= 0;
          m_fheld <= x_stall_d && !x_flush;
        end else if (x_flush) begin
          m_fwait <= 0;
          m_fdrop <= m_fdrop + 1;
        end
      end else if (m_fheld) begin
        if (!x_stall_d || x_flush) m_fheld <= 0;
      end else if (inst_data_ok) begin
        m_fdrop <= m_fdrop - 1;
      end
      if (m_dbusy) begin
        if (data_data_ok) m_dbusy <= 0;
      end else if (x_dreq && data_addr_ok) begin
        m_dbusy <= 1;
        m_dpend <= 0;
      end else if (x_dreq) begin
        m_dpend <= 1;
      end
      if (x_flush) begin
        m_dv <= 0; m_age <= 0;
      end else if (x_start) begin
        m_dv <= 1; m_age <= 1;
      end else if (m_dv && m_age < DC - 1) begin
        m_age <= m_age + 1;
      end else if (m_dv && !x_stall_m) begin
        m_dv <= 0;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (armed) begin
      vecs++;
      if (act_ctl !== exp_ctl) begin
        miss++;
        $display("FAIL ctl t=%0t act=%b exp=%b",
                 $time, act_ctl, exp_ctl);
      end
      if (!rst) begin
        vecs++;
        if (instr_f !== x_instr) begin
          miss++;
          $display("FAIL instr_f t=%0t act=%h exp=%h",
                   $time, instr_f, x_instr);
        end
      end
    end
  end

  task automatic chk1(input string n,
                      input logic a, input logic e);
    vecs++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s act=%b exp=%b", n, a, e);
    end
  endtask

  task automatic chk32(input string n,
                       input logic [31:0] a,
                       input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  task automatic chk_int(input string n,
                         input int a, input int e);
    vecs++;
    if (a != e) begin
      miss++;
      $display("FAIL %s act=%0d exp=%0d", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rs_d = '0; rt_d = '0;
    uses_rs_d = 0; uses_rt_d = 0; branch_d = 0;
    regwrite_e = 0; memtoreg_e = 0; writereg_e = '0;
    regwrite_m = 0; memtoreg_m = 0; writereg_m = '0;
    div_e = 0; mem_m = 0; exc_m = 0;
    inst_addr_ok = 0; inst_data_ok = 0;
    data_addr_ok = 0; data_data_ok = 0;
  endtask

  task automatic set_lu();
    memtoreg_e = 1; regwrite_e = 1;
    writereg_e = 5'd8; rs_d = 5'd8; uses_rs_d = 1;
  endtask

  task automatic clr_lu();
    memtoreg_e = 0; regwrite_e = 0;
    writereg_e = '0; rs_d = '0; uses_rs_d = 0;
  endtask

  initial begin
    int holds;
    int starts;
    rst = 1;
    inst_rdata = '0;
    idle_in();
    repeat (3) tick();
    #2;
    chk1("rst_en_f", en_f, 1'b0);
    chk1("rst_clr_w", clr_w, 1'b1);
    chk1("rst_ireq", inst_req, 1'b0);

    // first fetch: addr_ok @1, data_ok @4
    tick(); rst = 0; #2;
    chk1("f0_ireq", inst_req, 1'b1);
    chk1("f0_clr_d", clr_d, 1'b1);
    chk1("f0_en_f", en_f, 1'b0);
    tick(); inst_addr_ok = 1; #2;
    chk1("f1_en_f", en_f, 1'b0);
    tick(); inst_addr_ok = 0; #2;
    chk1("f2_ireq", inst_req, 1'b0);
    chk1("f2_clr_d", clr_d, 1'b1);
    tick(); #2;
    chk1("f3_clr_d", clr_d, 1'b1);
    tick(); inst_data_ok = 1;
    inst_rdata = 32'h1234_5678; #2;
    chk1("f4_en_f", en_f, 1'b1);
    chk1("f4_clr_d", clr_d, 1'b0);
    chk32("f4_instr", instr_f, 32'h1234_5678);
    tick(); inst_data_ok = 0; #2;
    chk1("f5_ireq", inst_req, 1'b1);

    // load-use with a fetch landing in the stall
    tick(); inst_addr_ok = 1; #2;
    tick(); inst_addr_ok = 0; inst_data_ok = 1;
    inst_rdata = 32'hAAAA_0001; set_lu(); #2;
    chk1("lu_en_f", en_f, 1'b0);
    chk1("lu_en_d", en_d, 1'b0);
    chk1("lu_clr_e", clr_e, 1'b1);
    chk1("lu_clr_d", clr_d, 1'b0);
    chk1("lu_en_e", en_e, 1'b1);
    tick(); inst_data_ok = 0;
    inst_rdata = 32'hDEAD_0000;
    memtoreg_e = 0; regwrite_e = 0; writereg_e = '0;
    memtoreg_m = 1; regwrite_m = 1;
    writereg_m = 5'd8; #2;
    chk1("lu1_en_f", en_f, 1'b1);
    chk1("lu1_en_d", en_d, 1'b1);
    chk1("lu1_clr_e", clr_e, 1'b0);
    chk32("lu1_instr", instr_f, 32'hAAAA_0001);
    tick(); idle_in(); #2;
    chk1("lu2_ireq", inst_req, 1'b1);

    // branch operand hazards and register 0
    tick(); branch_d = 1; uses_rs_d = 1;
    rs_d = 5'd9; memtoreg_m = 1; writereg_m = 5'd9; #2;
    chk1("bh_m_clr_e", clr_e, 1'b1);
    chk1("bh_m_en_d", en_d, 1'b0);
    tick(); memtoreg_m = 0; writereg_m = '0;
    uses_rs_d = 0; uses_rt_d = 1; rt_d = 5'd10;
    regwrite_e = 1; writereg_e = 5'd10; #2;
    chk1("bh_e_clr_e", clr_e, 1'b1);
    tick(); branch_d = 0; memtoreg_e = 1;
    writereg_e = '0; rs_d = '0; rt_d = '0;
    uses_rs_d = 1; uses_rt_d = 1; #2;
    chk1("r0_clr_e", clr_e, 1'b0);
    chk1("r0_en_d", en_d, 1'b1);

    // divide with a load-use landing mid-way
    tick(); idle_in(); div_e = 1; #2;
    chk1("dv_start", div_start, 1'b1);
    chk1("dv_en_e", en_e, 1'b0);
    chk1("dv_clr_m", clr_m, 1'b1);
    holds = 1;
    starts = 1;
    for (int i = 1; i < 40; i++) begin
      tick();
      if (i == 5) set_lu();
      if (i == 6) clr_lu();
      #2;
      if (i == 5) begin
        chk1("dvlu_clr_e", clr_e, 1'b0);
        chk1("dvlu_clr_m", clr_m, 1'b1);
      end
      if (div_start) starts++;
      if (en_e) break;
      holds++;
    end
    chk_int("dv_holds", holds, DC - 1);
    chk_int("dv_starts", starts, 1);
    chk1("dv_adv_clr_m", clr_m, 1'b0);

    // store: data_ok 3 cycles after addr_ok
    tick(); idle_in(); mem_m = 1;
    data_addr_ok = 1; #2;
    chk1("st0_dreq", data_req, 1'b1);
    chk1("st0_en_m", en_m, 1'b0);
    chk1("st0_clr_w", clr_w, 1'b1);
    tick(); data_addr_ok = 0; set_lu(); #2;
    chk1("st1_dreq", data_req, 1'b0);
    chk1("st1_clr_e", clr_e, 1'b0);
    chk1("st1_clr_w", clr_w, 1'b1);
    tick(); clr_lu(); #2;
    chk1("st2_en_m", en_m, 1'b0);
    tick(); data_data_ok = 1; #2;
    chk1("st3_en_m", en_m, 1'b1);
    chk1("st3_clr_w", clr_w, 1'b0);

    // late address accept
    tick(); data_data_ok = 0; #2;
    chk1("ld0_dreq", data_req, 1'b1);
    tick(); data_addr_ok = 1; #2;
    chk1("ld1_dreq", data_req, 1'b1);
    chk1("ld1_en_m", en_m, 1'b0);
    tick(); data_addr_ok = 0; data_data_ok = 1; #2;
    chk1("ld2_en_m", en_m, 1'b1);

    // exception with a fetch in flight
    tick(); idle_in(); inst_addr_ok = 1; #2;
    tick(); inst_addr_ok = 0; exc_m = 1; #2;
    chk1("ex_flush", exc_flush, 1'b1);
    chk1("ex_clr_d", clr_d, 1'b1);
    chk1("ex_clr_e", clr_e, 1'b1);
    chk1("ex_clr_m", clr_m, 1'b1);
    chk1("ex_clr_w", clr_w, 1'b1);
    chk1("ex_en_f", en_f, 1'b1);
    tick(); exc_m = 0; #2;
    chk1("exd_ireq", inst_req, 1'b0);
    tick(); inst_data_ok = 1;
    inst_rdata = 32'hBAD0_BAD0; #2;
    chk1("exd_en_f", en_f, 1'b0);
    chk1("exd_clr_d", clr_d, 1'b1);
    tick(); inst_data_ok = 0; #2;
    chk1("exv_ireq", inst_req, 1'b1);

    // exception held off by a busy data access
    tick(); mem_m = 1; data_addr_ok = 1; #2;
    tick(); data_addr_ok = 0; exc_m = 1; #2;
    chk1("exb_flush", exc_flush, 1'b0);
    tick(); data_data_ok = 1; #2;
    chk1("exb1_flush", exc_flush, 1'b0);
    tick(); data_data_ok = 0; mem_m = 0; #2;
    chk1("exb2_flush", exc_flush, 1'b1);

    // flush cancels a running divide
    tick(); idle_in(); div_e = 1; #2;
    repeat (3) tick();
    tick(); exc_m = 1; #2;
    chk1("dvx_start", div_start, 1'b0);
    tick(); exc_m = 0; #2;
    chk1("dvx_restart", div_start, 1'b1);

    // reset mid-divide and mid-fetch
    tick(); inst_addr_ok = 1; #2;
    tick(); inst_addr_ok = 0; rst = 1; #2;
    chk1("rm_en_e", en_e, 1'b0);
    chk1("rm_clr_m", clr_m, 1'b1);
    chk1("rm_ireq", inst_req, 1'b0);
    tick(); rst = 0; #2;
    chk1("rp_ireq", inst_req, 1'b1);
    chk1("rp_start", div_start, 1'b1);

    tick(); idle_in();
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
